// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// default geometry of the ROM interface.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W_DEF         = 7;
  localparam int DATA_W_DEF         = 32;
  localparam int START_ADDR_DEF     = 0;
  localparam int TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_FLUSH,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Program counter for the fetch stage: sequential increment with silent wrap,
// and a redirect load that takes priority over the increment.
module instruction_fetch_unit_fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int START_ADDR = START_ADDR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= ADDR_W'(START_ADDR);
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= w_pc_inc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage in front of the instruction ROM: issues reads at the PC, buffers
// one returned word and hands it to the execution engine via valid/ready.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | first cycle after reset release
// ST_REQ    | ROM enabled at pc, waiting for the read-complete strobe
// ST_HOLD   | word captured, waiting for the consumer to accept it
// ST_FLUSH  | one enable-low cycle so the ROM sees a fresh request
// ST_HALTED | no fetches issued until halt drops
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int START_ADDR     = START_ADDR_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_inst_addr,
  output logic              o_inst_enable,
  input  logic              i_inst_did_read,
  input  logic [DATA_W-1:0] i_inst_bus,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_halt,
  output logic              o_fetch_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_fetch_timeout;
  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_inc;
  logic              w_capture;
  logic              w_valid_clr;
  logic              w_timeout;

  instruction_fetch_unit_fetch_pc_reg #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_inc     (w_pc_inc),
    .i_load    (i_redirect),
    .i_load_pc (i_redirect_pc),
    .o_pc      (w_pc)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_pc_inc     = 1'b0;
    w_capture    = 1'b0;
    w_valid_clr  = 1'b0;
    w_timeout    = 1'b0;

    unique case (r_state)
      ST_IDLE: w_state_next = i_halt ? ST_HALTED : ST_REQ;
      ST_REQ: begin
        // Halt is deliberately not sampled here; the outstanding read finishes first.
        if (i_inst_did_read) begin
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_FLUSH;
        end else begin
          w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HOLD: begin
        if (i_instr_ready) begin
          w_valid_clr  = 1'b1;
          w_pc_inc     = 1'b1;
          w_state_next = i_halt ? ST_HALTED : ST_REQ;
        end
      end
      ST_FLUSH:  w_state_next = i_halt ? ST_HALTED : ST_REQ;
      ST_HALTED: if (!i_halt) w_state_next = ST_REQ;
      default:   w_state_next = ST_IDLE;
    endcase

    // Redirect overrides everything: a same-cycle strobe or timeout is dropped.
    if (i_redirect) begin
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      w_pc_inc     = 1'b0;
      w_cnt_next   = '0;
      w_valid_clr  = (r_state == ST_HOLD);
      w_state_next = (r_state == ST_HALTED) ? ST_HALTED : ST_FLUSH;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_instr         <= '0;
      r_instr_pc      <= '0;
      r_instr_valid   <= 1'b0;
      r_fetch_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_instr       <= i_inst_bus;
        r_instr_pc    <= w_pc;
        r_instr_valid <= 1'b1;
      end else if (w_valid_clr) begin
        r_instr_valid <= 1'b0;
      end
      if (w_timeout) begin
        r_fetch_timeout <= 1'b1;
      end
    end
  end

  assign o_inst_addr     = w_pc;
  assign o_inst_enable   = (r_state == ST_REQ);
  assign o_instr         = r_instr;
  assign o_instr_pc      = r_instr_pc;
  assign o_instr_valid   = r_instr_valid;
  assign o_fetch_timeout = r_fetch_timeout;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run scored against a transaction-level model of the fetch stream.
module tb_instruction_fetch_unit;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] o_inst_addr;
  logic          o_inst_enable;
  logic          i_inst_did_read = 1'b0;
  logic [DW-1:0] i_inst_bus = '0;
  logic [DW-1:0] o_instr;
  logic [AW-1:0] o_instr_pc;
  logic          o_instr_valid;
  logic          i_instr_ready = 1'b0;
  logic          i_redirect = 1'b0;
  logic [AW-1:0] i_redirect_pc = '0;
  logic          i_halt = 1'b0;
  logic          o_fetch_timeout;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [DW-1:0] rom [128];
  int en_cnt   = 0;
  int rom_lat  = 1;
  bit rand_lat = 1'b0;

  instruction_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .START_ADDR(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .o_inst_addr    (o_inst_addr),
    .o_inst_enable  (o_inst_enable),
    .i_inst_did_read(i_inst_did_read),
    .i_inst_bus     (i_inst_bus),
    .o_instr        (o_instr),
    .o_instr_pc     (o_instr_pc),
    .o_instr_valid  (o_instr_valid),
    .i_instr_ready  (i_instr_ready),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc),
    .i_halt         (i_halt),
    .o_fetch_timeout(o_fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ROM behaviour: strobes after rom_lat enabled cycles with the word at inst_addr.
  task automatic rom_respond();
    int r;
    if (o_inst_enable) begin
      if (en_cnt >= rom_lat) begin
        i_inst_did_read = 1'b1;
        i_inst_bus      = rom[o_inst_addr];
        en_cnt          = 0;
      end else begin
        i_inst_did_read = 1'b0;
        i_inst_bus      = $urandom;
        en_cnt++;
      end
    end else begin
      i_inst_did_read = 1'b0;
      i_inst_bus      = $urandom;
      en_cnt          = 0;
      if (rand_lat) begin
        r = $urandom_range(0, 9);
        rom_lat = (r < 8) ? (r % 4) : 16;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_redirect = 1'b0; i_halt = 1'b0; i_instr_ready = 1'b0;
    i_inst_did_read = 1'b0; en_cnt = 0; rand_lat = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_inst_did_read = 1'b1; i_inst_bus = $urandom; i_instr_ready = 1'b1;
    cyc(); cyc();
    chk_cnt++; if (o_inst_addr !== 7'd0) $display("FAIL rst_addr: got %0h expected 0", o_inst_addr); else pass_cnt++;
    chk_cnt++; if (o_inst_enable !== 1'b0) $display("FAIL rst_enable: got %0b expected 0", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_instr !== 32'd0) $display("FAIL rst_instr: got %0h expected 0", o_instr); else pass_cnt++;
    chk_cnt++; if (o_instr_pc !== 7'd0) $display("FAIL rst_instr_pc: got %0h expected 0", o_instr_pc); else pass_cnt++;
    chk_cnt++; if (o_instr_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", o_instr_valid); else pass_cnt++;
    chk_cnt++; if (o_fetch_timeout !== 1'b0) $display("FAIL rst_timeout: got %0b expected 0", o_fetch_timeout); else pass_cnt++;
  endtask

  task automatic test_sequential();
    int exp_pc, got, rise, firstv;
    do_reset();
    rom_lat = 1; i_instr_ready = 1'b1;
    exp_pc = 0; got = 0; rise = -1; firstv = -1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      cyc();
      if (o_inst_enable && rise < 0) rise = c;
      if (o_inst_enable) begin
        chk_cnt++; if (o_inst_addr !== AW'(exp_pc)) $display("FAIL seq_addr: got %0h expected %0h", o_inst_addr, exp_pc); else pass_cnt++;
      end
      if (o_instr_valid) begin
        if (firstv < 0) firstv = c;
        chk_cnt++; if (o_instr_pc !== AW'(exp_pc)) $display("FAIL seq_pc: got %0h expected %0h", o_instr_pc, exp_pc); else pass_cnt++;
        chk_cnt++; if (o_instr !== rom[exp_pc]) $display("FAIL seq_instr: got %0h expected %0h", o_instr, rom[exp_pc]); else pass_cnt++;
        exp_pc++; got++;
      end
      rom_respond();
    end
    chk_cnt++; if (got !== 4) $display("FAIL seq_count: got %0d expected 4", got); else pass_cnt++;
    chk_cnt++; if (firstv - rise !== 2) $display("FAIL seq_latency: got %0d expected 2", firstv - rise); else pass_cnt++;
  endtask

  task automatic test_stall();
    bit seen;
    logic [DW-1:0] snap_i;
    logic [AW-1:0] snap_p;
    do_reset();
    rom_lat = 1; i_instr_ready = 1'b0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc();
      if (o_instr_valid) seen = 1'b1;
      rom_respond();
    end
    chk_cnt++; if (seen !== 1'b1) $display("FAIL stall_valid_timeout: got %0b expected 1", seen); else pass_cnt++;
    snap_i = o_instr; snap_p = o_instr_pc;
    chk_cnt++; if (snap_p !== 7'd0) $display("FAIL stall_pc0: got %0h expected 0", snap_p); else pass_cnt++;
    chk_cnt++; if (snap_i !== rom[0]) $display("FAIL stall_word0: got %0h expected %0h", snap_i, rom[0]); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      i_inst_did_read = 1'b1; i_inst_bus = $urandom;
      cyc();
      chk_cnt++; if (o_instr_valid !== 1'b1) $display("FAIL stall_valid: got %0b expected 1", o_instr_valid); else pass_cnt++;
      chk_cnt++; if (o_instr !== rom[0]) $display("FAIL stall_instr: got %0h expected %0h", o_instr, rom[0]); else pass_cnt++;
      chk_cnt++; if (o_instr_pc !== 7'd0) $display("FAIL stall_instr_pc: got %0h expected 0", o_instr_pc); else pass_cnt++;
      chk_cnt++; if (o_inst_enable !== 1'b0) $display("FAIL stall_enable: got %0b expected 0", o_inst_enable); else pass_cnt++;
    end
    i_inst_did_read = 1'b0; i_instr_ready = 1'b1;
    cyc();
    rom_respond();
    chk_cnt++; if (o_instr_valid !== 1'b0) $display("FAIL stall_release_valid: got %0b expected 0", o_instr_valid); else pass_cnt++;
    chk_cnt++; if (o_inst_enable !== 1'b1) $display("FAIL stall_release_en: got %0b expected 1", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd1) $display("FAIL stall_release_addr: got %0h expected 1", o_inst_addr); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit done;
    do_reset();
    rom_lat = 1; i_instr_ready = 1'b1; done = 1'b0;
    cyc();
    rom_respond();
    i_redirect = 1'b1; i_redirect_pc = 7'd127;
    cyc();
    i_redirect = 1'b0;
    rom_respond();
    chk_cnt++; if (o_inst_enable !== 1'b0) $display("FAIL wrap_flush_en: got %0b expected 0", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd127) $display("FAIL wrap_flush_addr: got %0h expected 7f", o_inst_addr); else pass_cnt++;
    for (int c = 0; c < 20 && !done; c++) begin
      cyc();
      if (o_instr_valid) begin
        done = 1'b1;
        chk_cnt++; if (o_instr_pc !== 7'd127) $display("FAIL wrap_pc: got %0h expected 7f", o_instr_pc); else pass_cnt++;
        chk_cnt++; if (o_instr !== rom[127]) $display("FAIL wrap_instr: got %0h expected %0h", o_instr, rom[127]); else pass_cnt++;
      end
      rom_respond();
    end
    cyc();
    chk_cnt++; if (o_inst_enable !== 1'b1) $display("FAIL wrap_next_en: got %0b expected 1", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd0) $display("FAIL wrap_next_addr: got %0h expected 0", o_inst_addr); else pass_cnt++;
    chk_cnt++; if (o_fetch_timeout !== 1'b0) $display("FAIL wrap_no_flag: got %0b expected 0", o_fetch_timeout); else pass_cnt++;
  endtask

  task automatic test_redirect_discard();
    do_reset();
    rom_lat = 1; i_instr_ready = 1'b1;
    cyc(); rom_respond();
    cyc(); rom_respond();
    i_redirect = 1'b1; i_redirect_pc = 7'h40;
    cyc();
    i_redirect = 1'b0;
    rom_respond();
    chk_cnt++; if (o_instr_valid !== 1'b0) $display("FAIL redir_discard_valid: got %0b expected 0", o_instr_valid); else pass_cnt++;
    chk_cnt++; if (o_inst_enable !== 1'b0) $display("FAIL redir_flush_en: got %0b expected 0", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'h40) $display("FAIL redir_addr: got %0h expected 40", o_inst_addr); else pass_cnt++;
    cyc(); rom_respond();
    chk_cnt++; if (o_inst_enable !== 1'b1) $display("FAIL redir_req_en: got %0b expected 1", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'h40) $display("FAIL redir_req_addr: got %0h expected 40", o_inst_addr); else pass_cnt++;
    cyc(); rom_respond();
    cyc();
    chk_cnt++; if (o_instr_valid !== 1'b1) $display("FAIL redir_word_valid: got %0b expected 1", o_instr_valid); else pass_cnt++;
    chk_cnt++; if (o_instr_pc !== 7'h40) $display("FAIL redir_word_pc: got %0h expected 40", o_instr_pc); else pass_cnt++;
    chk_cnt++; if (o_instr !== rom[64]) $display("FAIL redir_word: got %0h expected %0h", o_instr, rom[64]); else pass_cnt++;
    rom_respond();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    rom_lat = 1000; i_instr_ready = 1'b1;
    cyc();
    n = 0;
    while (o_inst_enable && n < 40) begin
      chk_cnt++; if (o_fetch_timeout !== 1'b0) $display("FAIL to_early_flag: got %0b expected 0 at cycle %0d", o_fetch_timeout, n); else pass_cnt++;
      n++;
      rom_respond();
      cyc();
    end
    chk_cnt++; if (n !== TO) $display("FAIL to_req_cycles: got %0d expected %0d", n, TO); else pass_cnt++;
    chk_cnt++; if (o_fetch_timeout !== 1'b1) $display("FAIL to_flag: got %0b expected 1", o_fetch_timeout); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd0) $display("FAIL to_flush_addr: got %0h expected 0", o_inst_addr); else pass_cnt++;
    rom_lat = 1;
    rom_respond();
    cyc();
    chk_cnt++; if (o_inst_enable !== 1'b1) $display("FAIL to_retry_en: got %0b expected 1", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd0) $display("FAIL to_retry_addr: got %0h expected 0", o_inst_addr); else pass_cnt++;
    rom_respond(); cyc(); rom_respond(); cyc();
    chk_cnt++; if (o_instr_valid !== 1'b1) $display("FAIL to_retry_valid: got %0b expected 1", o_instr_valid); else pass_cnt++;
    chk_cnt++; if (o_instr !== rom[0]) $display("FAIL to_retry_word: got %0h expected %0h", o_instr, rom[0]); else pass_cnt++;
    chk_cnt++; if (o_fetch_timeout !== 1'b1) $display("FAIL to_sticky: got %0b expected 1", o_fetch_timeout); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (o_fetch_timeout !== 1'b0) $display("FAIL to_reset_clear: got %0b expected 0", o_fetch_timeout); else pass_cnt++;
  endtask

  task automatic test_halt();
    bit done;
    do_reset();
    rom_lat = 2; i_instr_ready = 1'b1; done = 1'b0;
    cyc(); rom_respond();
    i_halt = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      cyc();
      if (o_instr_valid) begin
        done = 1'b1;
        chk_cnt++; if (o_instr_pc !== 7'd0) $display("FAIL halt_word_pc: got %0h expected 0", o_instr_pc); else pass_cnt++;
        chk_cnt++; if (o_instr !== rom[0]) $display("FAIL halt_word: got %0h expected %0h", o_instr, rom[0]); else pass_cnt++;
      end
      rom_respond();
    end
    chk_cnt++; if (done !== 1'b1) $display("FAIL halt_delivered: got %0b expected 1", done); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      cyc(); rom_respond();
      chk_cnt++; if (o_inst_enable !== 1'b0) $display("FAIL halt_en: got %0b expected 0", o_inst_enable); else pass_cnt++;
      chk_cnt++; if (o_instr_valid !== 1'b0) $display("FAIL halt_valid: got %0b expected 0", o_instr_valid); else pass_cnt++;
    end
    i_halt = 1'b0;
    cyc(); rom_respond();
    chk_cnt++; if (o_inst_enable !== 1'b1) $display("FAIL halt_resume_en: got %0b expected 1", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd1) $display("FAIL halt_resume_addr: got %0h expected 1", o_inst_addr); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit done;
    do_reset();
    rom_lat = 0; i_instr_ready = 1'b1; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      cyc();
      if (o_instr_valid) done = 1'b1;
      rom_respond();
    end
    rom_lat = 3;
    cyc(); rom_respond();
    chk_cnt++; if (o_inst_enable !== 1'b1) $display("FAIL areset_pre_en: got %0b expected 1", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd1) $display("FAIL areset_pre_addr: got %0h expected 1", o_inst_addr); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (o_inst_enable !== 1'b0) $display("FAIL areset_en: got %0b expected 0", o_inst_enable); else pass_cnt++;
    chk_cnt++; if (o_inst_addr !== 7'd0) $display("FAIL areset_addr: got %0h expected 0", o_inst_addr); else pass_cnt++;
    chk_cnt++; if (o_instr !== 32'd0) $display("FAIL areset_instr: got %0h expected 0", o_instr); else pass_cnt++;
    chk_cnt++; if (o_instr_pc !== 7'd0) $display("FAIL areset_instr_pc: got %0h expected 0", o_instr_pc); else pass_cnt++;
    chk_cnt++; if (o_instr_valid !== 1'b0) $display("FAIL areset_valid: got %0b expected 0", o_instr_valid); else pass_cnt++;
  endtask

  // Model: accepted words follow the PC stream, which advances by one per
  // accepted word and jumps to the target on every redirect.
  task automatic test_random();
    int exp_pc, acc;
    bit prev_hold;
    logic [DW-1:0] prev_i;
    logic [AW-1:0] prev_p;
    do_reset();
    rand_lat = 1'b1; exp_pc = 0; acc = 0; prev_hold = 1'b0;
    for (int c = 0; c < 800; c++) begin
      cyc();
      if (o_inst_enable) begin
        chk_cnt++; if (o_inst_addr !== AW'(exp_pc)) $display("FAIL rnd_addr: got %0h expected %0h", o_inst_addr, exp_pc); else pass_cnt++;
      end
      if (prev_hold) begin
        chk_cnt++; if (o_instr_valid !== 1'b1 || o_instr !== prev_i || o_instr_pc !== prev_p)
          $display("FAIL rnd_hold: got v=%0b %0h@%0h expected v=1 %0h@%0h", o_instr_valid, o_instr, o_instr_pc, prev_i, prev_p);
        else pass_cnt++;
      end
      i_instr_ready = ($urandom_range(0, 3) != 0);
      i_redirect    = ($urandom_range(0, 29) == 0);
      i_redirect_pc = AW'($urandom);
      if (o_instr_valid && i_instr_ready) begin
        chk_cnt++; if (o_instr_pc !== AW'(exp_pc)) $display("FAIL rnd_pc: got %0h expected %0h", o_instr_pc, exp_pc); else pass_cnt++;
        chk_cnt++; if (o_instr !== rom[exp_pc]) $display("FAIL rnd_instr: got %0h expected %0h", o_instr, rom[exp_pc]); else pass_cnt++;
        exp_pc = (exp_pc + 1) % 128;
        acc++;
      end
      if (i_redirect) exp_pc = int'(i_redirect_pc);
      prev_hold = o_instr_valid && !i_instr_ready && !i_redirect;
      prev_i = o_instr; prev_p = o_instr_pc;
      rom_respond();
    end
    i_redirect = 1'b0;
    chk_cnt++; if (acc < 50) $display("FAIL rnd_throughput: got %0d accepted expected at least 50", acc); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0] = rom[0] | 32'd1;
    test_reset();
    test_sequential();
    test_stall();
    test_wrap();
    test_redirect_discard();
    test_timeout();
    test_halt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
